map_rom_arbiter: RTL
====================

// Module: map_rom_arbiter
// PURPOSE
//  Shares one map_rom between wall_tracer (bulk, latency-tolerant) and map_overlay (real-time, per-pixel).
//  Replaces the duplicate overlay map_rom instance in rbzero.
//  Overlay has priority. A one-entry overlay cell cache frees ROM cycles for the tracer.
//  A starvation counter guarantees the tracer forward progress.
// PARAMETERS
//  MAP_WIDTH_BITS   4  column index width
//  MAP_HEIGHT_BITS  4  row index width
//  STARVE_MAX       7  consecutive denied tracer cycles before the tracer is force-granted (>=1)
// PORTS
//  clk         in   1   system (pixel) clock
//  reset_n     in   1   synchronous, active-low reset
//  i_flush     in   1   invalidate overlay cache (driven by vsync)
//  i_ov_req    in   1   overlay request; col/row held stable until granted
//  i_ov_col    in   MAP_WIDTH_BITS   overlay cell column
//  i_ov_row    in   MAP_HEIGHT_BITS  overlay cell row
//  o_ov_gnt    out  1   overlay served this cycle, from ROM or cache (combinational)
//  o_ov_valid  out  1   o_ov_val valid; registered, 1 cycle after o_ov_gnt
//  o_ov_val    out  1   overlay cell value
//  i_tr_req    in   1   tracer request; col/row held until granted
//  i_tr_col    in   MAP_WIDTH_BITS   tracer cell column
//  i_tr_row    in   MAP_HEIGHT_BITS  tracer cell row
//  o_tr_gnt    out  1   tracer owns ROM this cycle (combinational)
//  o_tr_valid  out  1   o_tr_val valid; registered, 1 cycle after o_tr_gnt
//  o_tr_val    out  1   tracer cell value
//  o_map_col   out  MAP_WIDTH_BITS   address to map_rom (combinational mux)
//  o_map_row   out  MAP_HEIGHT_BITS  address to map_rom
//  i_map_val   in   1   map_rom data (combinational, same cycle)
// BEHAVIOUR
//  Reset (reset_n=0 at posedge):
//   - Cleared: *_valid, *_val, starve_cnt, cache_vld, cache col/row/val.
//   - Combinational outputs are forced to 0 while reset_n=0: *_gnt, o_map_col, o_map_row.
//   - Requests in flight are dropped; requesters must re-present them.
//  Cache hit: ov_hit = i_ov_req & cache_vld & ~i_flush & {i_ov_col,i_ov_row}=={cache_col,cache_row}.
//   - A hit never uses the ROM.
//  Arbitration, evaluated per cycle:
//   - force_tr = i_tr_req & (starve_cnt==STARVE_MAX)
//   - ov_rom   = i_ov_req & ~ov_hit & ~force_tr
//   - o_ov_gnt = ov_hit | ov_rom
//   - o_tr_gnt = i_tr_req & ~ov_rom
//   - ROM address = overlay address if ov_rom, else tracer address if o_tr_gnt, else 0.
//  Response, registered at the posedge ending the grant cycle:
//   - o_ov_valid <= o_ov_gnt; o_ov_val <= ov_hit ? cache_val : i_map_val (hold when not granted).
//   - o_tr_valid <= o_tr_gnt; o_tr_val <= i_map_val (hold when not granted).
//   - Fixed latency: data valid exactly 1 cycle after gnt. Back-to-back grants are allowed every cycle.
//  Cache update: on ov_rom, load cache_col/row/val from overlay address and i_map_val, and set cache_vld.
//   - i_flush clears cache_vld; flush wins over a same-cycle load.
//  Starvation counter (width $clog2(STARVE_MAX+1)):
//   - Increments when i_tr_req & ~o_tr_gnt.
//   - Clears on o_tr_gnt or ~i_tr_req.
//   - Saturates at STARVE_MAX.
//  Boundaries:
//   - Overlay hit plus tracer request: both granted in the same cycle.
//   - force_tr with an overlay miss: overlay gets gnt=0 and must hold its request. The overlay
//     renderer pre-fetches one cell ahead, so it tolerates one stall per STARVE_MAX+1 cycles.
//   - Requester drops req before gnt: nothing is issued and no valid is produced.
//  The tracer read path adds no stall when the overlay is idle (outside the overlay region).
// STRUCTURE
//  Shared include map_params.v:
//   - MAP_WIDTH_BITS, MAP_HEIGHT_BITS defaults.
//   - `MAPCOL/`MAPROW range macros, also used by map_rom, wall_tracer and map_overlay.
//  One sub-module, map_cell_cache:
//   - Ports: clk, reset_n, flush, lookup col/row -> hit/val, load strobe + col/row/val.
//  Arbitration, starvation counter and response registers stay in map_rom_arbiter.
//  rbzero instantiates a single map_rom behind this block.
// TESTING (bench uses the real map_rom; all checks are cycle-exact)
//  1. Reset mid-op: hold tr_req, pulse reset_n=0 for 1 cycle.
//     -> all outputs 0 that cycle; tr_valid=0 next cycle; cache misses on next overlay req.
//  2. Tracer only: tr_req (col 3,row 5) one cycle, ov idle.
//     -> tr_gnt same cycle; map_col=3, map_row=5; tr_valid=1 and tr_val=rom[5][3] next cycle.
//  3. Contention, miss: both req, ov (2,2) then ov (4,2) on alternating misses.
//     -> ov granted; tr_gnt=0; starve_cnt reaches 7.
//     -> 8th contended cycle: tr_gnt=1, ov_gnt=0; counter returns to 0.
//  4. Cache hit: ov (1,1) granted from ROM, then ov (1,1) held alongside tr (6,9).
//     -> both gnt=1; map_col=6, map_row=9; ov_val equals cached value; no ROM read for ov.
//  5. Flush: i_flush=1 coincident with a repeat ov (1,1).
//     -> treated as miss: ROM read, map_col=1; cache reloads next cycle only when flush=0.
//  6. Random stress, 10k cycles, random req and addresses with hold-until-gnt.
//     -> every valid value matches rom[row][col] of its granted request.
//     -> no tracer wait exceeds STARVE_MAX+1 cycles.

Source files
------------

// File: rtl/map_rom_arbiter_pkg.sv
// Shared definitions for the map_rom arbiter: default geometry, starvation limit
// and the ROM address source select.
package map_rom_arbiter_pkg;

    localparam int unsigned MapWidthBitsDef  = 4;
    localparam int unsigned MapHeightBitsDef = 4;
    localparam int unsigned StarveMaxDef     = 7;

    // Who drives the shared ROM address this cycle.
    typedef enum logic [1:0] {
        SrcNone,
        SrcOvRom,
        SrcTr
    } rom_src_e;

    // Starvation counter width: enough to hold 0..starve_max inclusive.
    function automatic int unsigned starve_cnt_width(input int unsigned starve_max);
        return (starve_max < 1) ? 1 : $clog2(starve_max + 1);
    endfunction

endpackage

// File: rtl/map_rom_arbiter_if.sv
// Bundles the overlay, tracer and map_rom sides of the arbiter. The arbiter uses the
// slave modport; the requesters/ROM side uses master.
interface map_rom_arbiter_if
    import map_rom_arbiter_pkg::*;
#(
    parameter int unsigned MAP_WIDTH_BITS  = MapWidthBitsDef,
    parameter int unsigned MAP_HEIGHT_BITS = MapHeightBitsDef
);

    logic                       i_flush;

    logic                       i_ov_req;
    logic [MAP_WIDTH_BITS-1:0]  i_ov_col;
    logic [MAP_HEIGHT_BITS-1:0] i_ov_row;
    logic                       o_ov_gnt;
    logic                       o_ov_valid;
    logic                       o_ov_val;

    logic                       i_tr_req;
    logic [MAP_WIDTH_BITS-1:0]  i_tr_col;
    logic [MAP_HEIGHT_BITS-1:0] i_tr_row;
    logic                       o_tr_gnt;
    logic                       o_tr_valid;
    logic                       o_tr_val;

    logic [MAP_WIDTH_BITS-1:0]  o_map_col;
    logic [MAP_HEIGHT_BITS-1:0] o_map_row;
    logic                       i_map_val;

    modport master (
        output i_flush,
        output i_ov_req, i_ov_col, i_ov_row,
        input  o_ov_gnt, o_ov_valid, o_ov_val,
        output i_tr_req, i_tr_col, i_tr_row,
        input  o_tr_gnt, o_tr_valid, o_tr_val,
        input  o_map_col, o_map_row,
        output i_map_val
    );

    modport slave (
        input  i_flush,
        input  i_ov_req, i_ov_col, i_ov_row,
        output o_ov_gnt, o_ov_valid, o_ov_val,
        input  i_tr_req, i_tr_col, i_tr_row,
        output o_tr_gnt, o_tr_valid, o_tr_val,
        output o_map_col, o_map_row,
        input  i_map_val
    );

endinterface

// File: rtl/map_cell_cache.sv
// One-entry cache of the last overlay cell fetched from the ROM. A flush invalidates the
// entry and takes precedence over a load in the same cycle.
module map_cell_cache #(
    parameter int unsigned MAP_WIDTH_BITS  = 4,
    parameter int unsigned MAP_HEIGHT_BITS = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush_i,
    input  logic [MAP_WIDTH_BITS-1:0]  lookup_col_i,
    input  logic [MAP_HEIGHT_BITS-1:0] lookup_row_i,
    output logic                       hit_o,
    output logic                       val_o,
    input  logic                       load_i,
    input  logic [MAP_WIDTH_BITS-1:0]  load_col_i,
    input  logic [MAP_HEIGHT_BITS-1:0] load_row_i,
    input  logic                       load_val_i
);

    logic                       vld_q, vld_d;
    logic [MAP_WIDTH_BITS-1:0]  col_q, col_d;
    logic [MAP_HEIGHT_BITS-1:0] row_q, row_d;
    logic                       val_q, val_d;

    // A flushing cycle must not hit: the entry may be stale for the new frame.
    always_comb begin
        hit_o = vld_q & ~flush_i & (lookup_col_i == col_q) & (lookup_row_i == row_q);
        val_o = val_q;
    end

    always_comb begin
        vld_d = vld_q;
        col_d = col_q;
        row_d = row_q;
        val_d = val_q;
        if (load_i) begin
            vld_d = 1'b1;
            col_d = load_col_i;
            row_d = load_row_i;
            val_d = load_val_i;
        end
        if (flush_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q <= 1'b0;
            col_q <= '0;
            row_q <= '0;
            val_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            col_q <= col_d;
            row_q <= row_d;
            val_q <= val_d;
        end
    end

endmodule

// File: rtl/map_rom_arbiter.sv
// Shares one map_rom between the real-time overlay (priority, cached) and the bulk wall
// tracer, with a starvation counter that force-grants the tracer after STARVE_MAX denials.
module map_rom_arbiter
    import map_rom_arbiter_pkg::*;
#(
    parameter int unsigned MAP_WIDTH_BITS  = MapWidthBitsDef,
    parameter int unsigned MAP_HEIGHT_BITS = MapHeightBitsDef,
    parameter int unsigned STARVE_MAX      = StarveMaxDef
) (
    input logic              clk,
    input logic              reset_n,
    map_rom_arbiter_if.slave bus
);

    localparam int unsigned CntWidth = starve_cnt_width(STARVE_MAX);

    logic                cache_hit;
    logic                cache_val;
    logic                ov_hit;
    logic                force_tr;
    logic                ov_rom;
    logic                ov_gnt;
    logic                tr_gnt;
    rom_src_e            rom_src;

    logic [CntWidth-1:0] starve_cnt_q, starve_cnt_d;
    logic                ov_valid_q, ov_valid_d;
    logic                ov_val_q, ov_val_d;
    logic                tr_valid_q, tr_valid_d;
    logic                tr_val_q, tr_val_d;

    map_cell_cache #(
        .MAP_WIDTH_BITS (MAP_WIDTH_BITS),
        .MAP_HEIGHT_BITS(MAP_HEIGHT_BITS)
    ) u_cache (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (bus.i_flush),
        .lookup_col_i(bus.i_ov_col),
        .lookup_row_i(bus.i_ov_row),
        .hit_o       (cache_hit),
        .val_o       (cache_val),
        .load_i      (ov_rom),
        .load_col_i  (bus.i_ov_col),
        .load_row_i  (bus.i_ov_row),
        .load_val_i  (bus.i_map_val)
    );

    // Every grant is gated by reset_n so nothing is issued or loaded while in reset.
    always_comb begin
        ov_hit   = reset_n & bus.i_ov_req & cache_hit;
        force_tr = bus.i_tr_req & (starve_cnt_q == CntWidth'(STARVE_MAX));
        ov_rom   = reset_n & bus.i_ov_req & ~cache_hit & ~force_tr;
        ov_gnt   = ov_hit | ov_rom;
        tr_gnt   = reset_n & bus.i_tr_req & ~ov_rom;
        if (ov_rom) begin
            rom_src = SrcOvRom;
        end else if (tr_gnt) begin
            rom_src = SrcTr;
        end else begin
            rom_src = SrcNone;
        end
    end

    always_comb begin
        bus.o_map_col = '0;
        bus.o_map_row = '0;
        unique case (rom_src)
            SrcOvRom: begin
                bus.o_map_col = bus.i_ov_col;
                bus.o_map_row = bus.i_ov_row;
            end
            SrcTr: begin
                bus.o_map_col = bus.i_tr_col;
                bus.o_map_row = bus.i_tr_row;
            end
            SrcNone: begin
                bus.o_map_col = '0;
                bus.o_map_row = '0;
            end
            default: begin
                bus.o_map_col = '0;
                bus.o_map_row = '0;
            end
        endcase
    end

    // A withdrawn or served tracer request restarts the starvation window.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.i_tr_req || tr_gnt) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CntWidth'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_comb begin
        ov_valid_d = ov_gnt;
        ov_val_d   = ov_val_q;
        tr_valid_d = tr_gnt;
        tr_val_d   = tr_val_q;
        if (ov_gnt) begin
            ov_val_d = ov_hit ? cache_val : bus.i_map_val;
        end
        if (tr_gnt) begin
            tr_val_d = bus.i_map_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
            ov_valid_q   <= 1'b0;
            ov_val_q     <= 1'b0;
            tr_valid_q   <= 1'b0;
            tr_val_q     <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            ov_valid_q   <= ov_valid_d;
            ov_val_q     <= ov_val_d;
            tr_valid_q   <= tr_valid_d;
            tr_val_q     <= tr_val_d;
        end
    end

    always_comb begin
        bus.o_ov_gnt   = ov_gnt;
        bus.o_tr_gnt   = tr_gnt;
        bus.o_ov_valid = ov_valid_q;
        bus.o_ov_val   = ov_val_q;
        bus.o_tr_valid = tr_valid_q;
        bus.o_tr_val   = tr_val_q;
    end

endmodule
